// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter in front of a single shared WIDTH-bit bitwise logic unit.
// One operation in flight: IDLE accepts, EXEC computes, RESP holds the tagged result.
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int N = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  output logic [N-1:0]         req_ready,
  input  logic [3*N-1:0]       req_op,
  input  logic [N*WIDTH-1:0]   req_a,
  input  logic [N*WIDTH-1:0]   req_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_err,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t             state_reg;
  logic [IDW-1:0]     rr_ptr_reg;
  logic [IDW-1:0]     id_reg;
  logic [2:0]         op_reg;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;

  logic [2:0]         op_arr [N];
  logic [WIDTH-1:0]   a_arr  [N];
  logic [WIDTH-1:0]   b_arr  [N];

  logic               grant_found;
  logic [IDW-1:0]     winner;
  logic [IDW-1:0]     rr_ptr_next;
  logic [WIDTH-1:0]   res_data;
  logic               res_err;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_slice
      assign op_arr[gi] = req_op[3*gi +: 3];
      assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
      assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
    end
  endgenerate

  // Scan from the farthest offset down so the candidate closest to rr_ptr wins.
  always_comb begin
    int idx;
    idx         = 0;
    grant_found = 1'b0;
    winner      = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_reg) + k) % N;
      if (req_valid[idx]) begin
        grant_found = 1'b1;
        winner      = IDW'(idx);
      end
    end
  end

  assign rr_ptr_next = (winner == IDW'(N - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    req_ready = '0;
    if (!rst && state_reg == IDLE && grant_found) begin
      req_ready[winner] = 1'b1;
    end
  end

  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_reg)
      3'd0:    res_data = a_reg & b_reg;
      3'd1:    res_data = a_reg | b_reg;
      3'd2:    res_data = ~a_reg;
      3'd3:    res_data = ~(a_reg & b_reg);
      3'd4:    res_data = ~(a_reg | b_reg);
      3'd5:    res_data = a_reg ^ b_reg;
      3'd6:    res_data = ~(a_reg ^ b_reg);
      default: res_err  = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      id_reg     <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      out_err    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (grant_found) begin
            op_reg     <= op_arr[winner];
            a_reg      <= a_arr[winner];
            b_reg      <= b_arr[winner];
            id_reg     <= winner;
            rr_ptr_reg <= rr_ptr_next;
            state_reg  <= EXEC;
          end
        end
        EXEC: begin
          out_data  <= res_data;
          out_id    <= id_reg;
          out_err   <= res_err;
          out_valid <= 1'b1;
          state_reg <= RESP;
        end
        RESP: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule
